mem_stage_ls: RTL and testbench

Parametrised memory-access pipeline stage, sitting between EXE and WB. It waits for a variable-latency data-memory response (`data_ok`) and buffers it if WB stalls. It extracts and sign/zero-extends byte, halfword and word loads, and exposes forwarding data plus a "result ready" qualifier to ID. A flush input kills the resident instruction and silently drains its orphaned memory response.

---
 rtl/mem_stage_ls.sv | 99 +++++++++
 tb/tb_mem_stage_ls.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ls.sv
// mem_stage_ls: MEM pipeline stage that waits for, buffers and extends data-memory responses and drains orphaned ones after a flush.
module mem_stage_ls #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int RA_W     = 5,
    parameter int MAX_DROP = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          es_to_ms_valid,
    input  logic [PC_W+RA_W+DATA_W+5:0]   es_to_ms_bus,
    output logic                          ms_allowin,
    input  logic                          ws_allowin,
    output logic                          ms_to_ws_valid,
    output logic [PC_W+RA_W+DATA_W:0]     ms_to_ws_bus,
    input  logic                          data_sram_data_ok,
    input  logic [DATA_W-1:0]             data_sram_rdata,
    input  logic                          flush,
    output logic                          ms_valid,
    output logic [RA_W-1:0]               ms_to_ds_dest,
    output logic                          ms_fwd_ready,
    output logic [DATA_W-1:0]             ms_forward_data
);
    localparam int CNT_W = $clog2(MAX_DROP + 1);

    logic [PC_W+RA_W+DATA_W+5:0] bus_r;
    logic [PC_W-1:0]   pc;
    logic              gr_we;
    logic [RA_W-1:0]   dest;
    logic [DATA_W-1:0] alu_result;
    logic              res_from_mem;
    logic              mem_we;
    logic [2:0]        ld_op;
    logic              got;
    logic [DATA_W-1:0] rbuf;
    logic [CNT_W-1:0]  drop_cnt;
    logic              wait_resp;
    logic              resp_ok;
    logic              ms_ready_go;
    logic              capture;
    logic              drop_inc;
    logic              drop_dec;
    logic [DATA_W-1:0] rsel;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] final_result;

    assign {pc, gr_we, dest, alu_result, res_from_mem, mem_we, ld_op} = bus_r;

    assign wait_resp   = res_from_mem | mem_we;
    // a response belongs to the resident instruction only once every orphan has drained
    assign resp_ok     = data_sram_data_ok && (drop_cnt == '0);
    assign ms_ready_go = !wait_resp | got | resp_ok;
    assign ms_allowin  = !ms_valid | (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign capture     = ms_valid && !got && resp_ok && !ms_allowin && !flush;
    assign drop_inc    = flush && ms_valid && wait_resp && !got && !resp_ok;
    assign drop_dec    = data_sram_data_ok && (drop_cnt != '0);

    assign rsel   = got ? rbuf : data_sram_rdata;
    assign byte_v = 8'(rsel >> {alu_result[1:0], 3'b000});
    assign half_v = alu_result[1] ? rsel[31:16] : rsel[15:0];
    assign ld_val = ld_op == 3'd1 ? {{(DATA_W-8){byte_v[7]}}, byte_v} :
                    ld_op == 3'd2 ? {{(DATA_W-16){half_v[15]}}, half_v} :
                    ld_op == 3'd3 ? {{(DATA_W-8){1'b0}}, byte_v} :
                    ld_op == 3'd4 ? {{(DATA_W-16){1'b0}}, half_v} : rsel;
    assign final_result = res_from_mem ? ld_val : alu_result;

    assign ms_to_ws_bus    = {pc, gr_we, dest, final_result};
    assign ms_to_ds_dest   = (ms_valid && gr_we) ? dest : '0;
    assign ms_fwd_ready    = ms_valid && gr_we && ms_ready_go;
    assign ms_forward_data = final_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
            got      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ms_valid <= flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
            got      <= (flush || ms_allowin) ? 1'b0 : capture ? 1'b1 : got;
            if (drop_inc && !drop_dec && drop_cnt != CNT_W'(MAX_DROP))
                drop_cnt <= drop_cnt + CNT_W'(1);
            else if (drop_dec && !drop_inc)
                drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin && !flush)
            bus_r <= es_to_ms_bus;
        if (capture)
            rbuf <= data_sram_rdata;
    end

    drop_overflow: assert property (@(posedge clk) disable iff (reset)
        !(drop_inc && !drop_dec && drop_cnt == CNT_W'(MAX_DROP)));
endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: directed scenario tests for mem_stage_ls with hand-computed expectations.
module tb_mem_stage_ls;
    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;
    logic        ms_valid;
    logic [4:0]  ms_to_ds_dest;
    logic        ms_fwd_ready;
    logic [31:0] ms_forward_data;
    int checks = 0;
    int errors = 0;

    mem_stage_ls dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .flush(flush), .ms_valid(ms_valid), .ms_to_ds_dest(ms_to_ds_dest),
        .ms_fwd_ready(ms_fwd_ready), .ms_forward_data(ms_forward_data)
    );

    always #5 clk = ~clk;

    function automatic logic [74:0] mk(logic [31:0] pc, logic gw, logic [4:0] d, logic [31:0] alu,
                                        logic rfm, logic mw, logic [2:0] op);
        return {pc, gw, d, alu, rfm, mw, op};
    endfunction

    task automatic test_reset;
        reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0;
        @(negedge clk); #1;
        checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ms_valid); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_ws_valid: got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_to_ds_dest !== 5'd0) begin errors++; $display("FAIL reset_dest: got %h want 0", ms_to_ds_dest); end
        checks++; if (ms_fwd_ready !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b want 0", ms_fwd_ready); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [69:0] exp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            es_to_ms_valid = (i < 4);
            es_to_ms_bus = mk(32'h100 + 32'(4*i), 1'b1, 5'(i+1), 32'hA0 + 32'(i), 1'b0, 1'b0, 3'd0);
            #1;
            if (i > 0) begin
                exp = {32'h100 + 32'(4*(i-1)), 1'b1, 5'(i), 32'hA0 + 32'(i-1)};
                checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b want 1", i, ms_to_ws_valid); end
                checks++; if (ms_to_ws_bus !== exp) begin errors++; $display("FAIL b2b_bus%0d: got %h want %h", i, ms_to_ws_bus, exp); end
                checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin%0d: got %b want 1", i, ms_allowin); end
            end
        end
    endtask

    task automatic test_lb_wait;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h200, 1'b1, 5'd3, 32'h1002, 1'b1, 1'b0, 3'd1);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); es_to_ms_valid = 1'b0; data_sram_rdata = 32'h5A5A_5A5A; #1;
            checks++; if (ms_fwd_ready !== 1'b0) begin errors++; $display("FAIL lb_fwd_wait%0d: got %b want 0", c, ms_fwd_ready); end
            checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL lb_valid_wait%0d: got %b want 0", c, ms_to_ws_valid); end
            checks++; if (ms_to_ds_dest !== 5'd3) begin errors++; $display("FAIL lb_dest%0d: got %h want 3", c, ms_to_ds_dest); end
        end
        @(negedge clk); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234; #1;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_forward_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_data: got %h want ffffffff", ms_forward_data); end
        checks++; if (ms_fwd_ready !== 1'b1) begin errors++; $display("FAIL lb_fwd: got %b want 1", ms_fwd_ready); end
        @(negedge clk); data_sram_data_ok = 1'b0; #1;
        checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL lb_left: got %b want 0", ms_valid); end
    endtask

    task automatic test_lhu_stall;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h300, 1'b1, 5'd4, 32'h2002, 1'b1, 1'b0, 3'd4);
        @(negedge clk); es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000; #1;
        checks++; if (ms_forward_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data0: got %h want 00008001", ms_forward_data); end
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL lhu_allowin0: got %b want 0", ms_allowin); end
        @(negedge clk); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5555_AAAA; #1;
        checks++; if (ms_forward_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data1: got %h want 00008001", ms_forward_data); end
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL lhu_valid1: got %b want 1", ms_to_ws_valid); end
        @(negedge clk); ws_allowin = 1'b1; #1;
        checks++; if (ms_to_ws_bus !== {32'h300, 1'b1, 5'd4, 32'h0000_8001}) begin errors++; $display("FAIL lhu_bus: got %h", ms_to_ws_bus); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL lhu_allowin2: got %b want 1", ms_allowin); end
        @(negedge clk); #1;
        checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL lhu_left: got %b want 0", ms_valid); end
    endtask

    task automatic test_flush_drain;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h400, 1'b1, 5'd6, 32'h3000, 1'b1, 1'b0, 3'd0);
        @(negedge clk); es_to_ms_valid = 1'b0; flush = 1'b1; #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fd_flush_valid: got %b want 0", ms_to_ws_valid); end
        @(negedge clk); flush = 1'b0; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h404, 1'b1, 5'd7, 32'h4000, 1'b1, 1'b0, 3'd0); #1;
        checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL fd_empty: got %b want 0", ms_valid); end
        @(negedge clk); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fd_drained: got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_fwd_ready !== 1'b0) begin errors++; $display("FAIL fd_drain_fwd: got %b want 0", ms_fwd_ready); end
        @(negedge clk); data_sram_data_ok = 1'b0; #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fd_wait: got %b want 0", ms_to_ws_valid); end
        @(negedge clk); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678; #1;
        checks++; if (ms_to_ws_bus !== {32'h404, 1'b1, 5'd7, 32'h1234_5678}) begin errors++; $display("FAIL fd_bus: got %h", ms_to_ws_bus); end
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL fd_valid: got %b want 1", ms_to_ws_valid); end
        @(negedge clk); data_sram_data_ok = 1'b0;
    endtask

    task automatic test_flush_same_cycle;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h500, 1'b1, 5'd8, 32'h5000, 1'b1, 1'b0, 3'd0);
        @(negedge clk); flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0000;
        es_to_ms_bus = mk(32'h504, 1'b1, 5'd9, 32'h5004, 1'b0, 1'b0, 3'd0); #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fs_valid: got %b want 0", ms_to_ws_valid); end
        @(negedge clk); flush = 1'b0; data_sram_data_ok = 1'b0; es_to_ms_valid = 1'b0; #1;
        checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL fs_not_accepted: got %b want 0", ms_valid); end
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h508, 1'b1, 5'd10, 32'h6001, 1'b1, 1'b0, 3'd1);
        @(negedge clk); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1122_3344; #1;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL fs_next_valid: got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_forward_data !== 32'h0000_0033) begin errors++; $display("FAIL fs_next_data: got %h want 00000033", ms_forward_data); end
        @(negedge clk); data_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset_midwait;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h600, 1'b1, 5'd11, 32'h7000, 1'b1, 1'b0, 3'd0);
        @(negedge clk); flush = 1'b1; es_to_ms_valid = 1'b0;
        @(negedge clk); flush = 1'b0; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h604, 1'b1, 5'd12, 32'h7004, 1'b1, 1'b0, 3'd0);
        @(negedge clk); es_to_ms_valid = 1'b0; #1;
        checks++; if (ms_to_ds_dest !== 5'd12) begin errors++; $display("FAIL rw_dest_before: got %h want 0c", ms_to_ds_dest); end
        #1 reset = 1'b1; #1;
        checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %b want 0", ms_valid); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rw_allowin: got %b want 1", ms_allowin); end
        checks++; if (ms_to_ds_dest !== 5'd0) begin errors++; $display("FAIL rw_dest: got %h want 0", ms_to_ds_dest); end
        @(negedge clk); reset = 1'b0; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h608, 1'b1, 5'd13, 32'h7008, 1'b1, 1'b0, 3'd0);
        @(negedge clk); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D; #1;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL rw_after_valid: got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_forward_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rw_after_data: got %h want cafef00d", ms_forward_data); end
        @(negedge clk); data_sram_data_ok = 1'b0;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_lb_wait;
        test_lhu_stall;
        test_flush_drain;
        test_flush_same_cycle;
        test_reset_midwait;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
